matvec_mxn: RTL and testbench



---
 rtl/matvec_mxn.sv | 196 +++++++++++++++++++
 tb/tb_matvec_mxn.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matvec_mxn.sv
// Signed M x N matrix-vector multiplier, y = W*x, one MAC per cycle with matrix retention.
// Define MATVEC_SAT_EN to clamp results to the OW-bit signed range instead of wrapping.
module matvec_mxn #(
   parameter int M  = 3,
   parameter int N  = 3,
   parameter int IW = 14,
   parameter int OW = 28
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 input_valid,
   output logic                 input_ready,
   input  logic signed [IW-1:0] input_data,
   input  logic                 new_matrix,
   output logic                 output_valid,
   input  logic                 output_ready,
   output logic signed [OW-1:0] output_data
);

   // state  | meaning
   // S_LOAD | accepting W (when new_matrix) then x elements
   // S_MAC  | N cycles of acc += W[r][k]*x[k] for the current row r
   // S_OUT  | result y[r] held on output_data until the output handshake

   localparam int AW = 2*IW + $clog2(N);
   localparam int MN = M*N;
   localparam int LW = $clog2(MN+N+1);
   localparam int RW = (M > 1) ? $clog2(M) : 1;
   localparam int KW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {S_LOAD, S_MAC, S_OUT} state_t;

   state_t               state_q, state_d;
   logic [LW-1:0]        cnt_q, cnt_d;
   logic                 nm_q, nm_d;
   logic [RW-1:0]        r_q, r_d;
   logic [KW-1:0]        k_q, k_d;
   logic signed [AW-1:0] acc_q, acc_d;
   logic signed [IW-1:0] w_q [MN];
   logic signed [IW-1:0] w_d [MN];
   logic signed [IW-1:0] x_q [N];
   logic signed [IW-1:0] x_d [N];
   logic                 ready_q, ready_d;
   logic                 valid_q, valid_d;
   logic signed [OW-1:0] data_q, data_d;

   int                   cnt_i;
   int                   widx;
   logic                 hs_in;
   logic                 nm_eff;
   logic                 load_last;
   logic signed [IW-1:0] w_sel;
   logic signed [IW-1:0] x_sel;
   logic signed [2*IW-1:0] prod;
   logic signed [AW-1:0] prod_ext;
   logic signed [AW-1:0] acc_sum;
   logic signed [OW-1:0] red;

   assign input_ready  = ready_q;
   assign output_valid = valid_q;
   assign output_data  = data_q;

   assign cnt_i = int'(cnt_q);
   assign widx  = int'(r_q) * N + int'(k_q);

   always_comb begin
      w_sel = '0;
      x_sel = '0;
      for (int i = 0; i < MN; i++) begin
         if (widx == i) w_sel = w_q[i];
      end
      for (int j = 0; j < N; j++) begin
         if (int'(k_q) == j) x_sel = x_q[j];
      end
   end

   // Products are exact in 2*IW bits; AW adds headroom for N terms so the sum never overflows.
   assign prod     = (2*IW)'(w_sel) * (2*IW)'(x_sel);
   assign prod_ext = AW'(prod);
   assign acc_sum  = ((k_q == '0) ? '0 : acc_q) + prod_ext;

   generate
      if (OW >= AW) begin : g_ext
         assign red = OW'(acc_sum);
      end else begin : g_narrow
`ifdef MATVEC_SAT_EN
         logic [AW-OW:0] top_bits;
         assign top_bits = acc_sum[AW-1:OW-1];
         always_comb begin
            if ((&top_bits) || !(|top_bits)) red = acc_sum[OW-1:0];
            else if (acc_sum[AW-1])          red = {1'b1, {(OW-1){1'b0}}};
            else                             red = {1'b0, {(OW-1){1'b1}}};
         end
`else
         assign red = acc_sum[OW-1:0];
`endif
      end
   endgenerate

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      nm_d      = nm_q;
      r_d       = r_q;
      k_d       = k_q;
      acc_d     = acc_q;
      w_d       = w_q;
      x_d       = x_q;
      ready_d   = ready_q;
      valid_d   = valid_q;
      data_d    = data_q;
      hs_in     = input_valid && ready_q;
      nm_eff    = (cnt_q == '0) ? new_matrix : nm_q;
      load_last = nm_eff ? (cnt_i == MN+N-1) : (cnt_i == N-1);

      case (state_q)
         S_LOAD: begin
            if (hs_in) begin
               if (cnt_q == '0) nm_d = new_matrix;
               for (int i = 0; i < MN; i++) begin
                  if (nm_eff && cnt_i == i) w_d[i] = input_data;
               end
               for (int j = 0; j < N; j++) begin
                  if ((nm_eff && cnt_i == MN+j) || (!nm_eff && cnt_i == j)) x_d[j] = input_data;
               end
               if (load_last) begin
                  cnt_d   = '0;
                  r_d     = '0;
                  k_d     = '0;
                  ready_d = 1'b0;
                  state_d = S_MAC;
               end else begin
                  cnt_d = cnt_q + LW'(1);
               end
            end
         end
         S_MAC: begin
            acc_d = acc_sum;
            if (int'(k_q) == N-1) begin
               k_d     = '0;
               data_d  = red;
               valid_d = 1'b1;
               state_d = S_OUT;
            end else begin
               k_d = k_q + KW'(1);
            end
         end
         S_OUT: begin
            if (output_ready) begin
               valid_d = 1'b0;
               if (int'(r_q) == M-1) begin
                  ready_d = 1'b1;
                  state_d = S_LOAD;
               end else begin
                  r_d     = r_q + RW'(1);
                  state_d = S_MAC;
               end
            end
         end
         default: begin
            ready_d = 1'b1;
            valid_d = 1'b0;
            state_d = S_LOAD;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_LOAD;
         cnt_q   <= '0;
         nm_q    <= 1'b0;
         r_q     <= '0;
         k_q     <= '0;
         acc_q   <= '0;
         for (int i = 0; i < MN; i++) w_q[i] <= '0;
         for (int j = 0; j < N; j++)  x_q[j] <= '0;
         ready_q <= 1'b1;
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         nm_q    <= nm_d;
         r_q     <= r_d;
         k_q     <= k_d;
         acc_q   <= acc_d;
         w_q     <= w_d;
         x_q     <= x_d;
         ready_q <= ready_d;
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

endmodule

// File: tb/tb_matvec_mxn.sv
// Bench for matvec_mxn: a 3x3 instance for the main scenarios and a 2x4 instance for non-square shape.
module tb_matvec_mxn;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset;

   logic               a_iv, a_ir, a_nm, a_ov, a_or;
   logic signed [13:0] a_id;
   logic signed [27:0] a_od;
   logic               b_iv, b_ir, b_nm, b_ov, b_or;
   logic signed [13:0] b_id;
   logic signed [27:0] b_od;

   matvec_mxn #(.M(3), .N(3), .IW(14), .OW(28)) dut_a (
      .clk(clk), .reset(reset),
      .input_valid(a_iv), .input_ready(a_ir), .input_data(a_id), .new_matrix(a_nm),
      .output_valid(a_ov), .output_ready(a_or), .output_data(a_od));

   matvec_mxn #(.M(2), .N(4), .IW(14), .OW(28)) dut_b (
      .clk(clk), .reset(reset),
      .input_valid(b_iv), .input_ready(b_ir), .input_data(b_id), .new_matrix(b_nm),
      .output_valid(b_ov), .output_ready(b_or), .output_data(b_od));

   int n_cmp = 0;
   int n_err = 0;
   int a_hs  = 0;

   logic signed [27:0] a_exp_q[$];
   logic signed [27:0] b_exp_q[$];
   int w_model [9];

   int w_basic [9];
   int x_basic [3];
   int w_min   [9];
   int x_min   [3];
   int x_unit  [3];

   always @(posedge clk) if (!reset && a_iv && a_ir) a_hs <= a_hs + 1;

   function automatic logic signed [27:0] red28(input longint s);
`ifdef MATVEC_SAT_EN
      if (s > 64'sd134217727)  return {1'b0, {27{1'b1}}};
      if (s < -64'sd134217728) return {1'b1, {27{1'b0}}};
`endif
      return 28'(s);
   endfunction

   task automatic a_push(input logic signed [13:0] d, input logic nm, input bit rnd);
      bit done = 0;
      if (rnd) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      a_iv = 1'b1;
      a_id = d;
      a_nm = nm;
      for (int t = 0; t < 50 && !done; t++) begin
         @(negedge clk);
         if (a_ir) done = 1;
         @(posedge clk); #1;
      end
      a_iv = 1'b0;
      a_nm = 1'($urandom_range(0, 1));
      if (!done) begin
         n_cmp++; n_err++;
         $display("FAIL a_input_timeout: input_ready=%0b, required 1 within 50 cycles", a_ir);
      end
   endtask

   task automatic a_problem(input bit nm, input int w [9], input int x [3], input bit rnd);
      longint sum;
      bit first = 1;
      if (nm) w_model = w;
      for (int r = 0; r < 3; r++) begin
         sum = 0;
         for (int k = 0; k < 3; k++) sum += longint'(w_model[r*3+k]) * longint'(x[k]);
         a_exp_q.push_back(red28(sum));
      end
      if (nm) begin
         for (int i = 0; i < 9; i++) begin
            a_push(14'(w[i]), first ? 1'b1 : 1'($urandom_range(0, 1)), rnd);
            first = 0;
         end
      end
      for (int k = 0; k < 3; k++) begin
         a_push(14'(x[k]), first ? 1'(nm) : 1'($urandom_range(0, 1)), rnd);
         first = 0;
      end
   endtask

   task automatic a_collect(input int count, input bit rnd, input string name);
      int got = 0;
      bit hold = 0;
      logic signed [27:0] held;
      logic signed [27:0] exp;
      a_or = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      for (int t = 0; t < 2000 && got < count; t++) begin
         @(negedge clk);
         if (a_ov) begin
            if (hold) begin
               n_cmp++;
               if (a_od !== held) begin
                  n_err++;
                  $display("FAIL %s_stable: output_data=%0d, required held %0d", name, a_od, held);
               end
            end
            if (a_or) begin
               n_cmp++;
               if (a_exp_q.size() == 0) begin
                  n_err++;
                  $display("FAIL %s_extra: output_data=%0d, required no output", name, a_od);
               end else begin
                  exp = a_exp_q.pop_front();
                  if (a_od !== exp) begin
                     n_err++;
                     $display("FAIL %s_row%0d: output_data=%0d, required %0d", name, got, a_od, exp);
                  end
               end
               got++;
               hold = 0;
            end else begin
               hold = 1;
               held = a_od;
            end
         end
         @(posedge clk); #1;
         a_or = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      a_or = 1'b0;
      if (got < count) begin
         n_cmp++; n_err++;
         $display("FAIL %s_timeout: outputs=%0d, required %0d", name, got, count);
      end
   endtask

   task automatic a_latency(input int required, input string name);
      int n = 0;
      bit seen = 0;
      for (int t = 0; t < 20 && !seen; t++) begin
         @(negedge clk);
         if (a_ov) seen = 1;
         else n++;
         @(posedge clk); #1;
      end
      n_cmp++;
      if (!seen || n != required) begin
         n_err++;
         $display("FAIL %s_latency: cycles=%0d, required %0d", name, n, required);
      end
   endtask

   task automatic a_idle_check(input int cycles, input string name);
      bit bad = 0;
      repeat (cycles) begin
         @(negedge clk);
         if (a_ov !== 1'b0) bad = 1;
      end
      @(posedge clk); #1;
      n_cmp++;
      if (bad) begin
         n_err++;
         $display("FAIL %s_idle: output_valid seen 1, required 0 for %0d cycles", name, cycles);
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (2) begin @(posedge clk); #1; end
      @(negedge clk);
      n_cmp++;
      if (a_ov !== 1'b0 || a_ir !== 1'b1 || a_od !== 28'sd0) begin
         n_err++;
         $display("FAIL reset_state: valid=%0b ready=%0b data=%0d, required 0 1 0", a_ov, a_ir, a_od);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      a_problem(0, w_basic, x_basic, 0);
      a_collect(3, 0, "zero_after_reset");
   endtask

   task automatic test_basic;
      a_problem(1, w_basic, x_basic, 0);
      a_latency(3, "basic");
      a_collect(3, 0, "basic");
   endtask

   task automatic test_back_to_back;
      int h0 = a_hs;
      a_problem(0, w_basic, x_unit, 0);
      @(negedge clk);
      n_cmp++;
      if (a_ir !== 1'b0 || (a_hs - h0) != 3) begin
         n_err++;
         $display("FAIL reuse_handshakes: count=%0d ready=%0b, required 3 0", a_hs - h0, a_ir);
      end
      @(posedge clk); #1;
      a_collect(3, 0, "reuse");
   endtask

   task automatic test_saturation;
      a_problem(1, w_min, x_min, 0);
      a_collect(3, 0, "saturation");
   endtask

   task automatic test_backpressure;
      a_problem(1, w_basic, x_basic, 1);
      a_collect(3, 1, "backpressure");
      a_idle_check(100, "backpressure");
   endtask

   task automatic test_reset_mid;
      a_problem(1, w_basic, x_basic, 0);
      a_collect(1, 0, "reset_mid_row0");
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      a_exp_q.delete();
      for (int i = 0; i < 9; i++) w_model[i] = 0;
      @(negedge clk);
      n_cmp++;
      if (a_ov !== 1'b0 || a_ir !== 1'b1) begin
         n_err++;
         $display("FAIL reset_mid_state: valid=%0b ready=%0b, required 0 1", a_ov, a_ir);
      end
      @(posedge clk); #1;
      a_problem(0, w_basic, x_basic, 0);
      a_collect(3, 0, "reset_mid_zero");
      a_problem(1, w_basic, x_basic, 0);
      a_collect(3, 0, "reset_mid_reload");
   endtask

   task automatic b_push(input logic signed [13:0] d, input logic nm);
      bit done = 0;
      b_iv = 1'b1;
      b_id = d;
      b_nm = nm;
      for (int t = 0; t < 50 && !done; t++) begin
         @(negedge clk);
         if (b_ir) done = 1;
         @(posedge clk); #1;
      end
      b_iv = 1'b0;
      if (!done) begin
         n_cmp++; n_err++;
         $display("FAIL b_input_timeout: input_ready=%0b, required 1 within 50 cycles", b_ir);
      end
   endtask

   task automatic test_non_square;
      int n = 0;
      int got = 0;
      bit seen = 0;
      logic signed [27:0] exp;
      b_exp_q.push_back(28'sd70);
      b_exp_q.push_back(-28'sd70);
      for (int i = 1; i <= 4; i++) b_push(14'(i), i == 1);
      for (int i = 1; i <= 4; i++) b_push(14'(-i), 1'b0);
      for (int i = 5; i <= 8; i++) b_push(14'(i), 1'b1);
      for (int t = 0; t < 20 && !seen; t++) begin
         @(negedge clk);
         if (b_ov) seen = 1;
         else n++;
         @(posedge clk); #1;
      end
      n_cmp++;
      if (!seen || n != 4) begin
         n_err++;
         $display("FAIL non_square_latency: cycles=%0d, required 4", n);
      end
      b_or = 1'b1;
      for (int t = 0; t < 100 && got < 2; t++) begin
         @(negedge clk);
         if (b_ov) begin
            exp = b_exp_q.pop_front();
            n_cmp++;
            if (b_od !== exp) begin
               n_err++;
               $display("FAIL non_square_row%0d: output_data=%0d, required %0d", got, b_od, exp);
            end
            got++;
         end
         @(posedge clk); #1;
      end
      b_or = 1'b0;
      if (got < 2) begin
         n_cmp++; n_err++;
         $display("FAIL non_square_timeout: outputs=%0d, required 2", got);
      end
   endtask

   initial begin
      w_basic = '{10, -20, 30, 50, -60, 70, 80, 100, -110};
      x_basic = '{40, 30, -20};
      x_unit  = '{1, 0, 0};
      for (int i = 0; i < 9; i++) w_min[i] = -8192;
      x_min   = '{-8192, -8192, -8192};
      for (int i = 0; i < 9; i++) w_model[i] = 0;
      a_iv = 1'b0; a_id = '0; a_nm = 1'b0; a_or = 1'b0;
      b_iv = 1'b0; b_id = '0; b_nm = 1'b0; b_or = 1'b0;

      test_reset;
      test_basic;
      test_back_to_back;
      test_saturation;
      test_backpressure;
      test_reset_mid;
      test_non_square;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
